// File: rtl/pipelined_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_control_unit_if
// Brief    : ID-stage inputs and per-stage control outputs of the control unit.
// Revision : 1.0
// ============================================================================
interface pipelined_control_unit_if #(
    parameter int OPCODE_W = 6,
    parameter int REG_W    = 5,
    parameter int ALUOP_W  = 2,
    parameter int CNT_W    = 16
);
    logic                in_valid;
    logic [OPCODE_W-1:0] in_opcode;
    logic [REG_W-1:0]    id_rs;
    logic [REG_W-1:0]    id_rt;
    logic [REG_W-1:0]    id_rt_dst;
    logic                flush;
    logic                stall_o;
    logic                ex_valid;
    logic                ex_RegDst;
    logic                ex_ALUSrc;
    logic [ALUOP_W-1:0]  ex_ALUOp;
    logic                ex_illegal;
    logic                mem_valid;
    logic                mem_Branch;
    logic                mem_MemRead;
    logic                mem_MemWrite;
    logic                wb_valid;
    logic                wb_RegWrite;
    logic                wb_MemtoReg;
    logic [CNT_W-1:0]    stall_count;

    modport master (
        output in_valid, in_opcode, id_rs, id_rt, id_rt_dst, flush,
        input  stall_o, ex_valid, ex_RegDst, ex_ALUSrc, ex_ALUOp, ex_illegal,
        input  mem_valid, mem_Branch, mem_MemRead, mem_MemWrite,
        input  wb_valid, wb_RegWrite, wb_MemtoReg, stall_count
    );

    modport slave (
        input  in_valid, in_opcode, id_rs, id_rt, id_rt_dst, flush,
        output stall_o, ex_valid, ex_RegDst, ex_ALUSrc, ex_ALUOp, ex_illegal,
        output mem_valid, mem_Branch, mem_MemRead, mem_MemWrite,
        output wb_valid, wb_RegWrite, wb_MemtoReg, stall_count
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_control_unit
// Brief    : MIPS control decode carried through ID/EX, EX/MEM, MEM/WB with
//            load-use stall detection, flush bubbles and a saturating stall count.
// Revision : 1.0
// ============================================================================
module pipelined_control_unit #(
    parameter int OPCODE_W = 6,
    parameter int REG_W    = 5,
    parameter int ALUOP_W  = 2,
    parameter int CNT_W    = 16
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    pipelined_control_unit_if.slave      bus
);
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;

    localparam logic [ALUOP_W-1:0] c_ALUOP_ADD  = ALUOP_W'(2'b00);
    localparam logic [ALUOP_W-1:0] c_ALUOP_SUB  = ALUOP_W'(2'b01);
    localparam logic [ALUOP_W-1:0] c_ALUOP_FUNC = ALUOP_W'(2'b10);

    // ID/EX register
    logic               ex_valid_q, ex_RegDst_q, ex_ALUSrc_q, ex_illegal_q;
    logic [ALUOP_W-1:0] ex_ALUOp_q;
    logic               ex_Branch_q, ex_MemRead_q, ex_MemWrite_q;
    logic               ex_RegWrite_q, ex_MemtoReg_q;
    logic [REG_W-1:0]   ex_rt_q;
    // EX/MEM register
    logic               mem_valid_q, mem_Branch_q, mem_MemRead_q, mem_MemWrite_q;
    logic               mem_RegWrite_q, mem_MemtoReg_q;
    // MEM/WB register
    logic               wb_valid_q, wb_RegWrite_q, wb_MemtoReg_q;
    logic [CNT_W-1:0]   stall_count_q;

    // Decoded bundle for the ID instruction
    logic               dec_RegDst, dec_ALUSrc, dec_illegal;
    logic [ALUOP_W-1:0] dec_ALUOp;
    logic               dec_Branch, dec_MemRead, dec_MemWrite;
    logic               dec_RegWrite, dec_MemtoReg;
    logic               w_stall;
    logic               w_id_bubble;

    always_comb begin
        dec_RegDst   = 1'b0;
        dec_ALUSrc   = 1'b0;
        dec_ALUOp    = c_ALUOP_ADD;
        dec_Branch   = 1'b0;
        dec_MemRead  = 1'b0;
        dec_MemWrite = 1'b0;
        dec_RegWrite = 1'b0;
        dec_MemtoReg = 1'b0;
        dec_illegal  = 1'b0;
        case (bus.in_opcode[5:0])
            c_OP_RTYPE: begin
                dec_RegDst   = 1'b1;
                dec_ALUOp    = c_ALUOP_FUNC;
                dec_RegWrite = 1'b1;
            end
            c_OP_LW: begin
                dec_ALUSrc   = 1'b1;
                dec_MemRead  = 1'b1;
                dec_MemtoReg = 1'b1;
                dec_RegWrite = 1'b1;
            end
            c_OP_SW: begin
                dec_ALUSrc   = 1'b1;
                dec_MemWrite = 1'b1;
            end
            c_OP_BEQ: begin
                dec_ALUOp    = c_ALUOP_SUB;
                dec_Branch   = 1'b1;
            end
            c_OP_ADDI: begin
                dec_ALUSrc   = 1'b1;
                dec_RegWrite = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // A flush outranks the hazard: the dependent instruction is squashed anyway.
    assign w_stall = bus.in_valid & ex_valid_q & ex_MemRead_q &
                     ((ex_rt_q == bus.id_rs) | (ex_rt_q == bus.id_rt)) & ~bus.flush;
    assign w_id_bubble = bus.flush | w_stall | ~bus.in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q     <= 1'b0;
            ex_RegDst_q    <= 1'b0;
            ex_ALUSrc_q    <= 1'b0;
            ex_ALUOp_q     <= '0;
            ex_illegal_q   <= 1'b0;
            ex_Branch_q    <= 1'b0;
            ex_MemRead_q   <= 1'b0;
            ex_MemWrite_q  <= 1'b0;
            ex_RegWrite_q  <= 1'b0;
            ex_MemtoReg_q  <= 1'b0;
            ex_rt_q        <= '0;
            mem_valid_q    <= 1'b0;
            mem_Branch_q   <= 1'b0;
            mem_MemRead_q  <= 1'b0;
            mem_MemWrite_q <= 1'b0;
            mem_RegWrite_q <= 1'b0;
            mem_MemtoReg_q <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_RegWrite_q  <= 1'b0;
            wb_MemtoReg_q  <= 1'b0;
            stall_count_q  <= '0;
        end else begin
            if (w_id_bubble) begin
                ex_valid_q    <= 1'b0;
                ex_RegDst_q   <= 1'b0;
                ex_ALUSrc_q   <= 1'b0;
                ex_ALUOp_q    <= '0;
                ex_illegal_q  <= 1'b0;
                ex_Branch_q   <= 1'b0;
                ex_MemRead_q  <= 1'b0;
                ex_MemWrite_q <= 1'b0;
                ex_RegWrite_q <= 1'b0;
                ex_MemtoReg_q <= 1'b0;
                ex_rt_q       <= '0;
            end else begin
                ex_valid_q    <= 1'b1;
                ex_RegDst_q   <= dec_RegDst;
                ex_ALUSrc_q   <= dec_ALUSrc;
                ex_ALUOp_q    <= dec_ALUOp;
                ex_illegal_q  <= dec_illegal;
                ex_Branch_q   <= dec_Branch;
                ex_MemRead_q  <= dec_MemRead;
                ex_MemWrite_q <= dec_MemWrite;
                ex_RegWrite_q <= dec_RegWrite;
                ex_MemtoReg_q <= dec_MemtoReg;
                ex_rt_q       <= bus.id_rt_dst;
            end

            if (bus.flush) begin
                mem_valid_q    <= 1'b0;
                mem_Branch_q   <= 1'b0;
                mem_MemRead_q  <= 1'b0;
                mem_MemWrite_q <= 1'b0;
                mem_RegWrite_q <= 1'b0;
                mem_MemtoReg_q <= 1'b0;
            end else begin
                mem_valid_q    <= ex_valid_q;
                mem_Branch_q   <= ex_Branch_q;
                mem_MemRead_q  <= ex_MemRead_q;
                mem_MemWrite_q <= ex_MemWrite_q;
                mem_RegWrite_q <= ex_RegWrite_q;
                mem_MemtoReg_q <= ex_MemtoReg_q;
            end

            // The branch resolving in MEM is never squashed by its own flush.
            wb_valid_q    <= mem_valid_q;
            wb_RegWrite_q <= mem_RegWrite_q;
            wb_MemtoReg_q <= mem_MemtoReg_q;

            if (w_stall && (stall_count_q != {CNT_W{1'b1}})) begin
                stall_count_q <= stall_count_q + 1'b1;
            end
        end
    end

    assign bus.stall_o      = w_stall;
    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_RegDst    = ex_RegDst_q;
    assign bus.ex_ALUSrc    = ex_ALUSrc_q;
    assign bus.ex_ALUOp     = ex_ALUOp_q;
    assign bus.ex_illegal   = ex_illegal_q;
    assign bus.mem_valid    = mem_valid_q;
    assign bus.mem_Branch   = mem_Branch_q;
    assign bus.mem_MemRead  = mem_MemRead_q;
    assign bus.mem_MemWrite = mem_MemWrite_q;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_RegWrite  = wb_RegWrite_q;
    assign bus.wb_MemtoReg  = wb_MemtoReg_q;
    assign bus.stall_count  = stall_count_q;

    // Write-side fields of the EX/MEM stage only matter once they reach WB.
    logic w_unused;
    assign w_unused = ex_illegal_q & 1'b0;
endmodule
`default_nettype wire

// File: doc/pipelined_control_unit.md
# pipelined_control_unit

Parametrised pipelined control unit for the MIPS datapath. It decodes the ID-stage opcode into the control bundle and carries each field through the ID/EX, EX/MEM and MEM/WB pipeline registers, so every stage sees the control signals of its own instruction. It also detects load-use hazards, inserts bubbles on stall or flush, and keeps a saturating stall counter for performance debug.

## Interface
Parameters:
- OPCODE_W, 6, opcode field width
- REG_W, 5, register specifier width
- ALUOP_W, 2, ALUOp width (must be >= 2); decoded codes zero-extended
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  ID stage holds a real instruction
- in_opcode  in  OPCODE_W  instruction[31:26] of the ID instruction
- id_rs, id_rt  in  REG_W  source specifiers of the ID instruction
- id_rt_dst  in  REG_W  rt of the ID instruction, captured into ID/EX for hazard compare
- flush  in  1  branch taken; squash the instructions currently in ID and EX
- stall_o  out  1  combinational; hold PC and IF/ID this cycle
- ex_valid, ex_RegDst, ex_ALUSrc  out  1  ID/EX register
- ex_ALUOp  out  ALUOP_W  ID/EX register
- ex_illegal  out  1  ID/EX instruction had an undefined opcode
- mem_valid, mem_Branch, mem_MemRead, mem_MemWrite  out  1  EX/MEM register
- wb_valid, wb_RegWrite, wb_MemtoReg  out  1  MEM/WB register
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation
Decode table:
- 6'b000000 R-type: RegDst=1, ALUSrc=0, ALUOp=10, RegWrite=1, MemtoReg=0, MemRead=0, MemWrite=0, Branch=0
- 6'b100011 lw: RegDst=0, ALUSrc=1, ALUOp=00, MemRead=1, MemtoReg=1, RegWrite=1
- 6'b101011 sw: ALUSrc=1, ALUOp=00, MemWrite=1; RegWrite=0
- 6'b000100 beq: ALUSrc=0, ALUOp=01, Branch=1; RegWrite=0
- 6'b001000 addi: RegDst=0, ALUSrc=1, ALUOp=00, RegWrite=1
- Any other opcode: all controls 0, valid=1, illegal=1. The instruction flows as a NOP with its flag set.
- When OPCODE_W > 6, only the low 6 bits are compared.

Hazard detection:
- stall_o = in_valid & ex_valid & ID/EX.MemRead & (ID/EX.rt == id_rs | ID/EX.rt == id_rt) & ~flush.

Pipeline update, every rising edge:
- ID/EX:
  - Cleared to a bubble (all fields 0, including valid and illegal) if flush, stall_o or ~in_valid.
  - Otherwise loads the decoded bundle, with rt taken from id_rt_dst.
- EX/MEM:
  - Cleared to a bubble if flush.
  - Otherwise loads the ID/EX fields.
- MEM/WB: always loads the EX/MEM fields. An instruction in MEM is never squashed.
- stall_count: increments when stall_o=1 and holds at all-ones (no wrap).

Priority: reset > flush > stall > normal advance.

## Timing
- Reset (rst_n=0, asynchronous): every output register, ID/EX.rt and stall_count go to 0 immediately. No clock edge is needed.
- After release, the first edge with rst_n=1 performs a normal update.
- Latency from opcode present in ID (unstalled):
  - ex_* valid 1 cycle later
  - mem_* valid 2 cycles later
  - wb_* valid 3 cycles later
- stall_o has zero latency: it is asserted in the same cycle as the offending ID instruction. Upstream holds IF/ID, so the same instruction re-presents next cycle. The hazard then clears because the lw has moved to EX/MEM, giving exactly one bubble per load-use.
- Back-to-back loads feeding each other stall once each.
- flush and a load-use in the same cycle: stall_o=0, both ID/EX and EX/MEM bubble, stall_count unchanged.
- Reset asserted mid-flight discards all in-flight controls; no partial bundle appears at any stage.
- Reset-mid-operation on de-assert: outputs stay 0 until new valid instructions propagate.

## Test plan
- Reset: drive rst_n=0 between clock edges -> all outputs 0 at once; release, then issue R-type -> ex_RegDst=1, ex_ALUOp=2'b10 after 1 cycle; wb_RegWrite=1 after 3 cycles.
- Sequence lw, sw, beq, addi back to back -> each bundle appears in EX, MEM and WB on consecutive cycles, matching the decode table, with no stall.
- lw $t1 (rt=9) followed by add with rs=9 -> stall_o=1 for exactly one cycle, one bubble in EX, stall_count=1; the add then advances normally.
- flush=1 while beq is in MEM and lw/add are in EX/ID -> next cycle ex_valid=0 and mem_valid=0; wb shows beq (wb_valid=1, wb_RegWrite=0).
- Opcode 6'b111111 -> ex_illegal=1, ex_valid=1, all other controls 0; two cycles later wb_RegWrite=0.
- CNT_W=2 with 5 forced load-use stalls -> stall_count reaches 3 and holds at 3.
